// File: rtl/prog_freq_divider.sv
// Runtime-programmable divider: one-cycle enable pulse every D cycles and a
// divided square wave. New divisors are applied at the period boundary or on i_Sync.
module prog_freq_divider #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Enable,
  input  logic             i_Load,
  input  logic [WIDTH-1:0] i_Divisor,
  input  logic             i_Sync,
  output logic             o_Pulse,
  output logic             o_Square,
  output logic             o_Pending,
  output logic             o_LoadErr
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] r_Count, r_Active, r_Next;
  logic [WIDTH-1:0] next_div, half_m1;
  logic             load_ok, load_bad, tc;

  assign load_ok  = i_Load && (i_Divisor >= WIDTH'(2));
  assign load_bad = i_Load && (i_Divisor <  WIDTH'(2));
  // A valid load on the applying edge wins over the stored pending value.
  assign next_div = load_ok ? i_Divisor : r_Next;
  assign tc       = i_Enable && (r_Count == r_Active - WIDTH'(1));
  assign half_m1  = (r_Active >> 1) - WIDTH'(1);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Count   <= '0;
      r_Active  <= DEF;
      r_Next    <= DEF;
      o_Pulse   <= 1'b0;
      o_Square  <= 1'b0;
      o_Pending <= 1'b0;
      o_LoadErr <= 1'b0;
    end else begin
      o_LoadErr <= load_bad;
      r_Next    <= next_div;
      if (i_Sync) begin
        r_Count   <= '0;
        r_Active  <= next_div;
        o_Pulse   <= 1'b0;
        o_Square  <= 1'b0;
        o_Pending <= 1'b0;
      end else if (tc) begin
        r_Count   <= '0;
        r_Active  <= next_div;
        o_Pulse   <= 1'b1;
        o_Square  <= 1'b1;
        o_Pending <= 1'b0;
      end else begin
        o_Pulse <= 1'b0;
        if (load_ok) o_Pending <= 1'b1;
        if (i_Enable) begin
          r_Count <= r_Count + WIDTH'(1);
          // Da >= 2 so this never coincides with terminal count.
          if (r_Count == half_m1) o_Square <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_freq_divider.sv
// Directed plus randomized bench for prog_freq_divider against a period-level
// reference model (elapsed cycles in period, active/pending divisor).
module tb_prog_freq_divider;
  localparam int WIDTH = 16;

  logic             i_Clock = 1'b0;
  logic             i_Reset = 1'b1;
  logic             i_Enable = 1'b0;
  logic             i_Load = 1'b0;
  logic [WIDTH-1:0] i_Divisor = '0;
  logic             i_Sync = 1'b0;
  logic             o_Pulse, o_Square, o_Pending, o_LoadErr;

  prog_freq_divider #(.WIDTH(WIDTH), .DEFAULT_DIV(4)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Enable(i_Enable), .i_Load(i_Load),
    .i_Divisor(i_Divisor), .i_Sync(i_Sync), .o_Pulse(o_Pulse), .o_Square(o_Square),
    .o_Pending(o_Pending), .o_LoadErr(o_LoadErr)
  );

  always #5 i_Clock = ~i_Clock;

  int n_vec = 0, n_err = 0;

  // Reference model: elapsed cycles in period, active and pending divisor.
  int m_e, m_D, m_nxt;
  bit m_start, m_pulse, m_pend, m_lerr;

  task automatic model_reset();
    m_e = 0; m_D = 4; m_nxt = 4;
    m_start = 0; m_pulse = 0; m_pend = 0; m_lerr = 0;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("pulse",   o_Pulse,   m_pulse);
    chk("square",  o_Square,  m_start && (m_e < m_D / 2));
    chk("pending", o_Pending, m_pend);
    chk("loaderr", o_LoadErr, m_lerr);
  endtask

  task automatic step(input bit en, input bit ld, input int div, input bit sy);
    bit lv;
    i_Enable = en; i_Load = ld; i_Divisor = WIDTH'(div); i_Sync = sy;
    @(posedge i_Clock);
    lv = ld && div >= 2;
    m_lerr = ld && div < 2;
    if (lv) m_nxt = div;
    if (sy) begin
      m_e = 0; m_D = m_nxt; m_pend = 0; m_start = 0; m_pulse = 0;
    end else if (en && m_e == m_D - 1) begin
      m_e = 0; m_D = m_nxt; m_pend = 0; m_start = 1; m_pulse = 1;
    end else begin
      if (en) m_e++;
      m_pulse = 0;
      if (lv) m_pend = 1;
    end
    #1;
    i_Load = 1'b0; i_Sync = 1'b0;
    chk_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  task automatic run_to(input int e);
    for (int i = 0; i < 70 && m_e != e; i++) step(1, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #12;
    chk_all();
    @(negedge i_Clock) i_Reset = 1'b0;

    // Default divisor 4 after reset.
    run(12);
    // Load 10 mid-period; current period keeps length 4.
    run_to(1);
    step(1, 1, 10, 0);
    run(25);
    // Return to 4, then rejected loads.
    step(1, 1, 4, 0);
    run(12);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    run(9);
    // Load 5 with sync, then 2, then 3.
    step(1, 1, 5, 1);
    run(12);
    step(1, 1, 2, 0);
    run(10);
    step(1, 1, 3, 1);
    run(8);
    // Freeze at count 2 for 7 cycles with divisor 4.
    step(1, 1, 4, 1);
    run(5);
    run_to(2);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
    run(8);
    // Load accepted while frozen, applied on next wrap.
    step(0, 1, 6, 0);
    run(14);
    // Sync while disabled applies pending divisor.
    step(1, 1, 7, 0);
    step(0, 0, 0, 1);
    run(16);
    // Async reset mid-period with a load pending.
    step(1, 1, 4, 1);
    run_to(1);
    step(1, 1, 9, 0);
    #2 i_Reset = 1'b1;
    #1 model_reset();
    chk_all();
    @(negedge i_Clock) i_Reset = 1'b0;
    run(12);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit en, ld, sy;
      int div;
      en  = ($urandom_range(0, 9) != 0);
      ld  = ($urandom_range(0, 11) == 0);
      sy  = ($urandom_range(0, 39) == 0);
      div = $urandom_range(0, 12);
      step(en, ld, div, sy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
